pipe_ctrl: RTL and testbench
============================

PIPE_CTRL -- requirements
Module: pipe_ctrl

Interface
REQ-001 Parameter: DIV_TIMEOUT, 40, maximum RUN-state cycles allowed before the divide is abandoned (range 2..255).
REQ-002 clk  in  1  single clock; all state changes on the rising edge.
REQ-003 rst  in  1  synchronous, active-low reset (rst==0 resets on the clk edge).
REQ-004 stallreq_id  in  1  ID-stage stall request (load-use).
REQ-005 stallreq_ex  in  1  EX-stage stall request (non-divide multi-cycle op).
REQ-006 div_req  in  1  EX holds a divide op; level signal, held until the op leaves EX.
REQ-007 div_done  in  1  divider result valid, single-cycle pulse.
REQ-008 flush_req  in  1  exception/flush request, single-cycle pulse.
REQ-009 stall  out  6  bit0 PC, bit1 IF, bit2 ID, bit3 EX, bit4 MEM, bit5 WB; 1 = hold stage.
REQ-010 flush  out  1  clear all pipeline registers this cycle.
REQ-011 div_start  out  1  one-cycle launch pulse to the divider.
REQ-012 div_abort  out  1  one-cycle cancel pulse to the divider.
REQ-013 div_timeout  out  1  one-cycle pulse when DIV_TIMEOUT expires.
REQ-014 stall_cnt  out  32  stalled-cycle counter (see Configuration).

Function
REQ-015 FSM states IDLE, RUN and DONE; stall, flush, div_start, div_abort and div_timeout are combinational from state, the cycle counter and the inputs.
REQ-016 Priority, highest first: flush_req, then divide FSM/stallreq_ex, then stallreq_id.
REQ-017 flush_req=1: flush=1, stall=6'b000000, next state IDLE, cycle counter cleared; div_abort=1 only if the state is RUN.
REQ-018 IDLE with div_req=1 and no flush: div_start=1, stall=6'b001111, next state RUN, cycle counter cleared.
REQ-019 RUN: stall=6'b001111; the cycle counter increments each cycle.
REQ-020 RUN with div_done=1: next state DONE.
REQ-021 RUN with counter==DIV_TIMEOUT-1 and div_done=0: div_timeout=1, div_abort=1, next state DONE.
REQ-022 If div_done and timeout coincide in RUN, div_done wins: no div_timeout, no div_abort.
REQ-023 DONE: the divide FSM releases the stall so the EX result advances; next state is IDLE unconditionally; div_req=1 in DONE does not relaunch.
REQ-024 div_done seen in IDLE or DONE is ignored.
REQ-025 With the FSM not stalling: stallreq_ex=1 gives stall=6'b001111; otherwise stallreq_id=1 gives stall=6'b000111; otherwise stall=6'b000000.
REQ-026 stallreq_ex and stallreq_id are honoured in DONE; only the divide-induced stall is released there.
REQ-027 A divide costs 1 launch cycle plus the RUN cycles plus 1 DONE cycle; div_done arriving k cycles after div_start gives k+1 stalled cycles.

Reset
REQ-028 With rst==0 at a clk edge: state IDLE, cycle counter 0, and stall_cnt 0.
REQ-029 While rst==0: stall=0, flush=0, div_start=0, div_abort=0 and div_timeout=0, regardless of the other inputs.
REQ-030 Reset asserted in RUN abandons the divide silently, with no div_abort pulse.

Configuration
REQ-031 Macro PIPE_CTRL_STALL_CNT_EN defined: stall_cnt increments by 1 each cycle with stall[0]=1, and saturates at 32'hFFFFFFFF.
REQ-032 Macro PIPE_CTRL_STALL_CNT_EN undefined: stall_cnt is tied to 32'h0 and no counter register exists.

Verification
REQ-033 stallreq_id=1 for 2 cycles -> stall=6'b000111 on exactly those 2 cycles and 0 after; stall_cnt=2 (macro on).
REQ-034 div_req rises in IDLE, div_done 5 cycles after div_start -> div_start on cycle 0, stall=6'b001111 on cycles 0..5, DONE on cycle 6 with stall=0, no relaunch while div_req stays high.
REQ-035 div_req with no div_done, DIV_TIMEOUT=40 -> div_timeout=1 and div_abort=1 on the 40th RUN cycle, DONE next, IDLE after.
REQ-036 flush_req on the 3rd RUN cycle with stallreq_id=1 -> flush=1, stall=0 and div_abort=1 that cycle, state IDLE next.
REQ-037 rst=0 for one edge in RUN -> next cycle IDLE, all pulse outputs 0, stall_cnt=0; with the macro off, stall_cnt=0 throughout.

Source files
------------

// File: rtl/pipe_ctrl.sv
// pipe_ctrl -- pipeline hazard controller.
// Builds the per-stage stall vector and the flush strobe, and sequences a
// multi-cycle divide: launch, wait for the result or time out, then release.
//
// Ports
//   clk          single clock, rising edge
//   rst          synchronous active-low reset
//   stallreq_id  ID-stage stall request (load-use)
//   stallreq_ex  EX-stage stall request (non-divide multi-cycle op)
//   div_req      EX holds a divide op (level)
//   div_done     divider result valid (pulse)
//   flush_req    exception/flush request (pulse)
//   stall[5:0]   hold PC, IF, ID, EX, MEM, WB (bit0..bit5)
//   flush        clear all pipeline registers this cycle
//   div_start    launch pulse to the divider
//   div_abort    cancel pulse to the divider
//   div_timeout  pulse when DIV_TIMEOUT RUN cycles elapse without a result
//   stall_cnt    saturating count of cycles with stall[0]=1
//
// Build option: define PIPE_CTRL_STALL_CNT_EN to build the stalled-cycle
// counter; without it stall_cnt is tied to zero.
//
// state | meaning
// ------+--------------------------------------------------------------
// IDLE  | no divide outstanding; div_req launches one
// RUN   | divider busy; EX and upstream held; timeout timer running
// DONE  | divide finished or abandoned; divide stall released for 1 cycle

module pipe_ctrl #(
  parameter int unsigned DIV_TIMEOUT = 40
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        stallreq_id,
  input  logic        stallreq_ex,
  input  logic        div_req,
  input  logic        div_done,
  input  logic        flush_req,
  output logic [5:0]  stall,
  output logic        flush,
  output logic        div_start,
  output logic        div_abort,
  output logic        div_timeout,
  output logic [31:0] stall_cnt
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [5:0] STALL_EX = 6'b001111;
  localparam logic [5:0] STALL_ID = 6'b000111;
  // The timer counts the RUN cycles still allowed; zero marks the last one.
  localparam logic [7:0] TMR_LOAD = 8'(DIV_TIMEOUT - 1);

  state_t     state, state_nxt;
  logic [7:0] tmr, tmr_nxt;
  logic [5:0] stall_lvl;

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      tmr   <= TMR_LOAD;
    end else begin
      state <= state_nxt;
      tmr   <= tmr_nxt;
    end
  end

  // Stall from the stage requests alone, used whenever the divide is not holding.
  always_comb begin
    stall_lvl = 6'b000000;
    if (stallreq_ex)      stall_lvl = STALL_EX;
    else if (stallreq_id) stall_lvl = STALL_ID;
  end

  always_comb begin
    state_nxt   = state;
    tmr_nxt     = tmr;
    stall       = 6'b000000;
    flush       = 1'b0;
    div_start   = 1'b0;
    div_abort   = 1'b0;
    div_timeout = 1'b0;
    if (!rst) begin
      // Outputs stay quiet during reset; the register reset handles the state.
      state_nxt = IDLE;
      tmr_nxt   = TMR_LOAD;
    end else if (flush_req) begin
      flush     = 1'b1;
      div_abort = (state == RUN);
      state_nxt = IDLE;
      tmr_nxt   = TMR_LOAD;
    end else begin
      case (state)
        IDLE: begin
          if (div_req) begin
            div_start = 1'b1;
            stall     = STALL_EX;
            state_nxt = RUN;
            tmr_nxt   = TMR_LOAD;
          end else begin
            stall = stall_lvl;
          end
        end
        RUN: begin
          stall   = STALL_EX;
          tmr_nxt = tmr - 8'd1;
          if (div_done) begin
            // A result on the last allowed cycle still counts as success.
            state_nxt = DONE;
          end else if (tmr == 8'd0) begin
            div_timeout = 1'b1;
            div_abort   = 1'b1;
            state_nxt   = DONE;
          end
        end
        DONE: begin
          // div_req is still high here while the result leaves EX; no relaunch.
          stall     = stall_lvl;
          state_nxt = IDLE;
        end
        default: state_nxt = IDLE;
      endcase
    end
  end

`ifdef PIPE_CTRL_STALL_CNT_EN
  logic [31:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt_q <= 32'h0;
    end else if (stall[0] && (stall_cnt_q != 32'hFFFF_FFFF)) begin
      stall_cnt_q <= stall_cnt_q + 32'd1;
    end
  end

  assign stall_cnt = stall_cnt_q;
`else
  assign stall_cnt = 32'h0;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: directed scenarios with literal
// expectations, then randomized traffic checked every cycle against a
// cycle-indexed behavioural model.

module tb_pipe_ctrl;

  localparam int T = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        stallreq_id = 1'b0;
  logic        stallreq_ex = 1'b0;
  logic        div_req = 1'b0;
  logic        div_done = 1'b0;
  logic        flush_req = 1'b0;
  logic [5:0]  stall;
  logic        flush;
  logic        div_start;
  logic        div_abort;
  logic        div_timeout;
  logic [31:0] stall_cnt;

  int n_checks = 0;
  int n_fail   = 0;

  // Model: a divide is outstanding from the cycle after its launch until it
  // ends; the release cycle is remembered by absolute cycle number.
  int     cyc        = 0;
  bit     m_busy     = 1'b0;
  int     m_launch   = 0;
  int     m_release  = -1;
  longint m_cnt      = 0;

  logic [5:0] e_stall;
  logic       e_flush, e_start, e_abort, e_to;

  pipe_ctrl #(.DIV_TIMEOUT(T)) dut (
    .clk         (clk),
    .rst         (rst),
    .stallreq_id (stallreq_id),
    .stallreq_ex (stallreq_ex),
    .div_req     (div_req),
    .div_done    (div_done),
    .flush_req   (flush_req),
    .stall       (stall),
    .flush       (flush),
    .div_start   (div_start),
    .div_abort   (div_abort),
    .div_timeout (div_timeout),
    .stall_cnt   (stall_cnt)
  );

  always #5 clk = ~clk;

  function automatic logic [5:0] req_stall();
    if (stallreq_ex) return 6'b001111;
    if (stallreq_id) return 6'b000111;
    return 6'b000000;
  endfunction

  function void model_outputs();
    e_stall = 6'b0; e_flush = 1'b0; e_start = 1'b0; e_abort = 1'b0; e_to = 1'b0;
    if (rst) begin
      if (flush_req) begin
        e_flush = 1'b1;
        e_abort = m_busy;
      end else if (m_busy) begin
        e_stall = 6'b001111;
        if (!div_done && (cyc - m_launch == T)) begin
          e_to    = 1'b1;
          e_abort = 1'b1;
        end
      end else if (m_release == cyc) begin
        e_stall = req_stall();
      end else if (div_req) begin
        e_start = 1'b1;
        e_stall = 6'b001111;
      end else begin
        e_stall = req_stall();
      end
    end
  endfunction

  function void model_update();
    if (!rst) begin
      m_busy    = 1'b0;
      m_release = -1;
      m_cnt     = 0;
    end else begin
      if (e_stall[0] && m_cnt < 64'h0000_0000_FFFF_FFFF) m_cnt++;
      if (flush_req) begin
        m_busy    = 1'b0;
        m_release = -1;
      end else if (m_busy) begin
        if (div_done || (cyc - m_launch == T)) begin
          m_busy    = 1'b0;
          m_release = cyc + 1;
        end
      end else if (m_release == cyc) begin
        m_release = -1;
      end else if (div_req) begin
        m_busy   = 1'b1;
        m_launch = cyc;
      end
    end
    cyc++;
  endfunction

  function automatic logic [31:0] exp_cnt();
`ifdef PIPE_CTRL_STALL_CNT_EN
    return 32'(m_cnt);
`else
    return 32'h0;
`endif
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h (cycle %0d, t=%0t)", name, act, exp, cyc, $time);
    end
  endtask

  // Compare every output against the model at the falling edge.
  task automatic sample();
    @(negedge clk);
    model_outputs();
    chk("model.stall",       32'(stall),       32'(e_stall));
    chk("model.flush",       32'(flush),       32'(e_flush));
    chk("model.div_start",   32'(div_start),   32'(e_start));
    chk("model.div_abort",   32'(div_abort),   32'(e_abort));
    chk("model.div_timeout", 32'(div_timeout), 32'(e_to));
    chk("model.stall_cnt",   stall_cnt,        exp_cnt());
  endtask

  task automatic advance();
    @(posedge clk);
    model_update();
    #1;
  endtask

  task automatic chk_quiet(input string name);
    chk({name, ".stall"}, 32'(stall), 32'h0);
    chk({name, ".flush"}, 32'(flush), 32'h0);
    chk({name, ".start"}, 32'(div_start), 32'h0);
    chk({name, ".abort"}, 32'(div_abort), 32'h0);
    chk({name, ".timeout"}, 32'(div_timeout), 32'h0);
  endtask

  initial begin
    // Reset, including with every request active.
    rst = 1'b0;
    sample(); chk_quiet("rst0"); chk("rst0.cnt", stall_cnt, 32'h0); advance();
    div_req = 1'b1; flush_req = 1'b1; stallreq_ex = 1'b1; div_done = 1'b1;
    sample(); chk_quiet("rst_busy_inputs"); advance();
    div_req = 1'b0; flush_req = 1'b0; stallreq_ex = 1'b0; div_done = 1'b0;
    rst = 1'b1;

    // Two-cycle load-use stall.
    stallreq_id = 1'b1;
    sample(); chk("id1.stall", 32'(stall), 32'h07); advance();
    sample(); chk("id2.stall", 32'(stall), 32'h07); advance();
    stallreq_id = 1'b0;
    sample(); chk("id_after.stall", 32'(stall), 32'h00);
`ifdef PIPE_CTRL_STALL_CNT_EN
    chk("id.stall_cnt", stall_cnt, 32'd2);
`else
    chk("id.stall_cnt", stall_cnt, 32'd0);
`endif
    advance();

    // Divide finishing 5 cycles after launch.
    div_req = 1'b1;
    sample(); chk("div5.c0.start", 32'(div_start), 32'h1); chk("div5.c0.stall", 32'(stall), 32'h0F); advance();
    for (int i = 1; i <= 5; i++) begin
      div_done = (i == 5);
      sample();
      chk("div5.run.stall", 32'(stall), 32'h0F);
      chk("div5.run.start", 32'(div_start), 32'h0);
      chk("div5.run.abort", 32'(div_abort), 32'h0);
      advance();
    end
    div_done = 1'b0;
    sample(); chk("div5.done.stall", 32'(stall), 32'h00); chk("div5.done.start", 32'(div_start), 32'h0); advance();
    div_req = 1'b0;
    sample(); chk("div5.idle.stall", 32'(stall), 32'h00); advance();

    // Divide that never completes: timeout on the 40th RUN cycle.
    div_req = 1'b1;
    sample(); chk("to.start", 32'(div_start), 32'h1); advance();
    for (int i = 1; i <= T; i++) begin
      sample();
      chk("to.run.timeout", 32'(div_timeout), 32'(i == T));
      chk("to.run.abort",   32'(div_abort),   32'(i == T));
      chk("to.run.stall",   32'(stall),       32'h0F);
      advance();
    end
    sample(); chk_quiet("to.done"); advance();
    div_req = 1'b0;
    sample(); chk_quiet("to.idle"); advance();

    // Flush on the 3rd RUN cycle with a load-use request pending.
    div_req = 1'b1;
    sample(); advance();
    sample(); advance();
    sample(); advance();
    flush_req = 1'b1; stallreq_id = 1'b1;
    sample();
    chk("fl.flush", 32'(flush), 32'h1);
    chk("fl.stall", 32'(stall), 32'h00);
    chk("fl.abort", 32'(div_abort), 32'h1);
    chk("fl.timeout", 32'(div_timeout), 32'h0);
    advance();
    flush_req = 1'b0; stallreq_id = 1'b0;
    sample(); chk("fl.next_launch", 32'(div_start), 32'h1); advance();
    div_done = 1'b1;
    sample(); chk("fl.run.abort", 32'(div_abort), 32'h0); advance();
    div_done = 1'b0; div_req = 1'b0;
    sample(); advance();

    // Reset in RUN abandons silently.
    div_req = 1'b1;
    sample(); advance();
    sample(); advance();
    rst = 1'b0; flush_req = 1'b1; div_done = 1'b1;
    sample(); chk_quiet("rst_run"); advance();
    rst = 1'b1; flush_req = 1'b0; div_done = 1'b0; div_req = 1'b0;
    sample(); chk_quiet("rst_run.after"); chk("rst_run.cnt", stall_cnt, 32'h0); advance();
    div_req = 1'b1;
    sample(); chk("rst_run.idle_launch", 32'(div_start), 32'h1); advance();
    div_req = 1'b0; flush_req = 1'b1;
    sample(); chk("rst_run.flush_abort", 32'(div_abort), 32'h1); advance();
    flush_req = 1'b0;

    // Randomized traffic; done probability varies so timeouts also occur.
    for (int seg = 0; seg < 20; seg++) begin
      int done_pct;
      done_pct = (seg % 3 == 0) ? 0 : ((seg % 3 == 1) ? 5 : 30);
      for (int i = 0; i < 200; i++) begin
        rst         = ($urandom_range(199) != 0);
        div_req     = ($urandom_range(99) < 50);
        div_done    = ($urandom_range(99) < done_pct);
        flush_req   = ($urandom_range(99) < ((seg % 3 == 0) ? 1 : 4));
        stallreq_ex = ($urandom_range(99) < 20);
        stallreq_id = ($urandom_range(99) < 25);
        sample();
        advance();
      end
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
